// File: rtl/irda_mir_tx_framer_if.sv
// Controller-side link of the MIR TX framer: the framer pulls bits with next_data
// and signals end of frame with dc_restart.
interface irda_mir_tx_framer_if;
  logic data_available;
  logic data_i;
  logic next_data;
  logic dc_restart;

  modport master (
    output data_available,
    output data_i,
    input  next_data,
    input  dc_restart
  );

  modport slave (
    input  data_available,
    input  data_i,
    output next_data,
    output dc_restart
  );
endinterface

// File: rtl/irda_mir_tx_framer.sv
// MIR TX framer: wraps controller bits in 0x7E flags, stuffs a 0 after five data 1s
// and drives the IR LED with one short pulse per emitted 0.
module irda_mir_tx_framer #(
  parameter int unsigned OPEN_FLAGS  = 2,
  parameter int unsigned CLOSE_FLAGS = 1,
  parameter int unsigned PULSE_CLKS  = 4
) (
  input  logic                       clk,
  input  logic                       wb_rst_n,
  input  logic                       mir_tx_enabled,
  input  logic                       bit_tick,
  irda_mir_tx_framer_if.slave        dc,
  output logic                       tx_bit,
  output logic                       tx_valid,
  output logic                       ir_tx,
  output logic                       tx_busy
);
  localparam int unsigned PulseW = $clog2(PULSE_CLKS + 1);
  localparam logic [7:0] Flag = 8'h7E;
  localparam logic [2:0] OpenFlags = 3'(OPEN_FLAGS);
  localparam logic [2:0] CloseFlags = 3'(CLOSE_FLAGS);
  localparam logic [PulseW-1:0] PulseClks = PulseW'(PULSE_CLKS);
  localparam logic [PulseW-1:0] PulseOne = PulseW'(1);

  typedef enum logic [1:0] {StIdle, StOpen, StData, StClose} state_e;

  state_e state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [2:0] flag_cnt_q, flag_cnt_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic [PulseW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic tx_bit_q, tx_bit_d;
  logic tx_valid_q, tx_valid_d;
  logic ir_tx_q, ir_tx_d;
  logic next_data_q, next_data_d;
  logic dc_restart_q, dc_restart_d;
  logic emit, emit_bit;
  logic [2:0] flag_inc;

  assign flag_inc = flag_cnt_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    flag_cnt_d   = flag_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    tx_bit_d     = tx_bit_q;
    tx_valid_d   = 1'b0;
    next_data_d  = 1'b0;
    dc_restart_d = 1'b0;
    emit         = 1'b0;
    emit_bit     = 1'b0;
    // The LED pulse runs off its own counter so it can finish after the frame closes.
    pulse_cnt_d  = (pulse_cnt_q != '0) ? pulse_cnt_q - PulseOne : '0;
    ir_tx_d      = (pulse_cnt_q != '0);

    if (!mir_tx_enabled) begin
      state_d      = StIdle;
      bit_idx_d    = 3'd0;
      flag_cnt_d   = 3'd0;
      ones_cnt_d   = 3'd0;
      pulse_cnt_d  = '0;
      ir_tx_d      = 1'b0;
      dc_restart_d = (state_q != StIdle);
    end else if (bit_tick) begin
      unique case (state_q)
        StIdle: begin
          ones_cnt_d = 3'd0;
          if (dc.data_available) begin
            state_d    = StOpen;
            bit_idx_d  = 3'd0;
            flag_cnt_d = 3'd0;
          end
        end
        StOpen, StClose: begin
          emit       = 1'b1;
          emit_bit   = Flag[bit_idx_q];
          ones_cnt_d = 3'd0;
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            flag_cnt_d = flag_inc;
            if (state_q == StOpen && flag_inc == OpenFlags) begin
              state_d    = StData;
              flag_cnt_d = 3'd0;
            end else if (state_q == StClose && flag_inc == CloseFlags) begin
              state_d      = StIdle;
              flag_cnt_d   = 3'd0;
              dc_restart_d = 1'b1;
            end
          end
        end
        StData: begin
          emit = 1'b1;
          if (ones_cnt_q == 3'd5) begin
            emit_bit   = 1'b0;
            ones_cnt_d = 3'd0;
          end else if (!dc.data_available) begin
            // First closing-flag bit goes out on this same tick.
            state_d    = StClose;
            emit_bit   = Flag[0];
            bit_idx_d  = 3'd1;
            flag_cnt_d = 3'd0;
            ones_cnt_d = 3'd0;
          end else begin
            emit_bit    = dc.data_i;
            next_data_d = 1'b1;
            if (!dc.data_i) begin
              ones_cnt_d = 3'd0;
            end else if (ones_cnt_q < 3'd5) begin
              ones_cnt_d = ones_cnt_q + 3'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (emit) begin
        tx_valid_d = 1'b1;
        tx_bit_d   = emit_bit;
        if (!emit_bit) begin
          pulse_cnt_d = PulseClks;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!wb_rst_n) begin
      state_q      <= StIdle;
      bit_idx_q    <= 3'd0;
      flag_cnt_q   <= 3'd0;
      ones_cnt_q   <= 3'd0;
      pulse_cnt_q  <= '0;
      tx_bit_q     <= 1'b0;
      tx_valid_q   <= 1'b0;
      ir_tx_q      <= 1'b0;
      next_data_q  <= 1'b0;
      dc_restart_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      flag_cnt_q   <= flag_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_valid_q   <= tx_valid_d;
      ir_tx_q      <= ir_tx_d;
      next_data_q  <= next_data_d;
      dc_restart_q <= dc_restart_d;
    end
  end

  assign dc.next_data  = next_data_q;
  assign dc.dc_restart = dc_restart_q;
  assign tx_bit        = tx_bit_q;
  assign tx_valid      = tx_valid_q;
  assign ir_tx         = ir_tx_q;
  assign tx_busy       = (state_q != StIdle);
endmodule

// File: doc/irda_mir_tx_framer.md
Name: irda_mir_tx_framer

Overview:
- Downstream neighbour of the MIR TX data controller.
- Pulls un-stuffed serial data bits from the controller with a `next_data` strobe.
- Wraps them in HDLC opening/closing flags (0x7E), inserts a stuffed 0 after five consecutive data 1s, and drives the IR LED with MIR pulse encoding (one short pulse per 0 bit).
- Pulses `dc_restart` back to the controller at end of frame.

Parameters:
- OPEN_FLAGS, 2, number of 0x7E flags sent before data (1..7).
- CLOSE_FLAGS, 1, number of 0x7E flags sent after data (1..7).
- PULSE_CLKS, 4, clocks `ir_tx` stays high for a 0 bit; must be less than the bit_tick period.

Ports:
- clk  in  1  system clock.
- wb_rst_n  in  1  synchronous reset, active low.
- mir_tx_enabled  in  1  MIR transmit enable; low forces IDLE.
- bit_tick  in  1  one-clock strobe at the MIR bit rate (1.152 MHz); period ≥ 4 clk and > PULSE_CLKS.
- data_available  in  1  controller holds a valid data bit.
- data_i  in  1  current data bit from the controller.
- next_data  out  1  one-clock strobe: data bit consumed.
- dc_restart  out  1  one-clock strobe: frame closed, controller must clear.
- tx_bit  out  1  line bit (post-stuffing) emitted at the last bit_tick.
- tx_valid  out  1  one-clock strobe, coincident with tx_bit update.
- ir_tx  out  1  IR LED drive.
- tx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock only, with `wb_rst_n` low sampled at a clk edge. All outputs go to 0, state goes to IDLE, and all counters clear.
- States: IDLE, OPEN, DATA, CLOSE. All transitions are evaluated only on a clk edge with `bit_tick` = 1, except the `mir_tx_enabled` abort.
- IDLE:
  - On bit_tick with mir_tx_enabled=1 and data_available=1, go to OPEN.
  - No bit is emitted on that tick; flag_cnt=0 and bit_idx=0.
- OPEN/CLOSE:
  - Each bit_tick emits bit bit_idx of 0x7E, LSB first (0,1,1,1,1,1,1,0).
  - bit_idx is 3 bits and wraps 7→0. At the wrap, flag_cnt increments.
  - OPEN → DATA when flag_cnt reaches OPEN_FLAGS.
  - CLOSE → IDLE when flag_cnt reaches CLOSE_FLAGS. On that transition, `dc_restart` pulses for 1 clk.
  - Flag bits are never stuffed. ones_cnt is forced to 0 throughout OPEN and CLOSE.
- DATA, evaluated in this priority order on each bit_tick:
  1. ones_cnt==5: emit 0 (stuff bit), ones_cnt←0, `next_data` not asserted.
  2. data_available=0: enter CLOSE with bit_idx=0 and flag_cnt=0, and emit the first flag bit on this same tick. Frame end is never detected in the middle of a stuff bit.
  3. Otherwise: emit data_i and assert `next_data` for exactly 1 clk, registered in the same clock as tx_valid. If data_i=1, ones_cnt increments (saturating at 5); if 0, ones_cnt←0.
- Controller timing: the controller updates data_i one clk after next_data. The bit_tick period of ≥4 clk guarantees data_i is stable at the next tick.
- Emission:
  - tx_bit and tx_valid are registered on the bit_tick edge.
  - tx_valid is 1 for exactly that clk; tx_bit holds its value until the next emission.
- ir_tx (MIR pulse encoding):
  - When the emitted bit is 0, ir_tx=1 for PULSE_CLKS clks, starting the clk after tx_valid, counted by pulse_cnt.
  - When the emitted bit is 1, ir_tx stays 0.
  - ir_tx is 0 whenever the state is IDLE and pulse_cnt=0.
- Abort: mir_tx_enabled=0 in any state takes effect at the next clk edge, independent of bit_tick:
  - state←IDLE, all counters clear, ir_tx←0, next_data←0.
  - dc_restart pulses for 1 clk if the state was not IDLE.
- Back-to-back frames: if data_available is still 1 when IDLE is re-entered, the next bit_tick starts a new OPEN. There is no minimum inter-frame gap beyond that idle tick.
- A mid-frame reset behaves like a power-up reset; dc_restart is not pulsed.

Test Plan:
- Single frame, data bits 1,0,1,1 then data_available=0, OPEN_FLAGS=2, CLOSE_FLAGS=1 → tx_bit sequence 01111110 01111110 1011 01111110; next_data pulses exactly 4 times; dc_restart pulses once after the final 0.
- Six data 1s followed by a 0 → emitted data section is 11111 0 1 0; the stuffed 0 carries no next_data pulse; a total of 7 next_data pulses.
- Data 1,1,1,1,1 and then data_available drops → stuff 0 is emitted first, then the closing flag; 5 next_data pulses.
- PULSE_CLKS=4, bit_tick every 8 clk, emitted bit 0 → ir_tx high for exactly 4 clk starting 1 clk after tx_valid. Emitted bit 1 → ir_tx stays low.
- mir_tx_enabled dropped during the 10th data bit → IDLE on the next clk, ir_tx=0, a single dc_restart pulse, and no further tx_valid.
- wb_rst_n held low for 1 clk mid-DATA (no clk without bit_tick excluded) → all outputs 0 on the following clk, no dc_restart; a new frame then starts cleanly from OPEN.
